handshake_ff_input: RTL and testbench
=====================================

Name: handshake_ff_input

Overview:
- Downstream consumer stage for the handshake flipflop output producer.
- Accepts an 8-bit valid/ready stream through a registered-ready skid buffer.
- Drains the buffer under an internal stall condition.
- Checks that consecutive values increment by 1 (mod 2^WIDTH) and accumulates beat count and checksum for the bench and status logic.

Parameters:
- WIDTH, 8, data width of i_value.
- CNT_WIDTH, 16, width of o_count and o_sum.

Ports:
- clock  input  1  single clock, rising edge
- reset_n  input  1  synchronous active-low reset
- i_value  input  WIDTH  upstream data
- i_valid  input  1  upstream valid
- o_ready  output  1  registered ready to upstream
- i_stall  input  1  sink stall; 1 = do not consume this cycle
- i_clear  input  1  synchronous clear of checker and statistics
- o_count  output  CNT_WIDTH  number of consumed beats, saturating
- o_sum  output  CNT_WIDTH  sum of consumed values, mod 2^CNT_WIDTH
- o_error  output  1  sticky sequence error
- o_err_value  output  WIDTH  first value that broke the sequence

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clock, reset_n).
  - While reset_n=0 at a rising edge, all flops clear: buffer empty, o_ready=0, o_count=0, o_sum=0, o_error=0, o_err_value=0, FSM=SYNC.
  - o_ready stays 0 during reset and for the first cycle after release, then rises.
  - Reset mid-transfer discards buffered beats.
- Transfer rules:
  - Accept = i_valid & o_ready.
  - o_ready = ~skid_valid & run, where run is a flop set one cycle after reset release. o_ready therefore never depends combinationally on i_stall.
  - stall = i_stall, ORed with the LFSR stall when the optional feature is enabled.
  - Consume = main_valid & ~stall.
- Buffer: 2 entries, main and skid.
  - Accept with main empty or consumed this cycle: the beat loads main.
  - Accept with main full and not consumed: the beat loads skid; o_ready drops next cycle.
  - Consume with skid full: skid moves to main and skid clears. No accept is possible that cycle because o_ready=0.
  - Consume with skid empty and no accept: main clears.
  - Order is strictly preserved; no beat is lost or duplicated.
- Latency:
  - A beat accepted at edge N sits in main after N and is consumed at edge N+1 at the earliest.
  - Sustained throughput is 1 beat/cycle when the stall is 0.
- Checker FSM, updated only on consume:
  - SYNC: record the value as expected+1 and go to RUN.
  - RUN: if the value equals expected, update expected and stay. Otherwise capture o_err_value, set o_error and go to ERR.
  - ERR: absorbing. Beats are still consumed and counted; o_err_value is not overwritten.
  - Expected value wraps: after 8'hFF comes 8'h00.
- Statistics:
  - On each consume, o_count += 1, saturating at all-ones.
  - On each consume, o_sum += zero-extended value, wrapping.
- i_clear:
  - Sets FSM=SYNC and zeroes o_count, o_sum, o_error and o_err_value.
  - Buffer contents and o_ready are unaffected.
  - Clear coincident with consume: clear wins and the consumed beat is dequeued but not counted or checked.
- All outputs are registered.

Optional Feature:
- Macro HANDSHAKE_FF_INPUT_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, loaded at reset) advances every cycle.
  - Internal stall is asserted when lfsr[1:0]==2'b00, giving about 25% self-backpressure.
  - This stall ORs with i_stall.
- Undefined: no LFSR logic; stall = i_stall only.

Decomposition:
- Shared package handshake_pkg holds:
  - Checker state enum (SYNC, RUN, ERR).
  - LFSR seed and tap constants.
  - Default WIDTH/CNT_WIDTH localparams.
- One natural sub-module: handshake_skid_buffer, the 2-entry registered-ready buffer with parameter WIDTH and valid/ready on both sides.
- The checker and statistics stay in the top module.

Test Plan:
- Reset held 3 cycles, then released; values 1,2,3 with stall=0 -> o_ready=0 during reset and for 1 cycle after release; o_count=3, o_sum=6, o_error=0.
- Stall held for 2 cycles while i_valid streams 5,6,7 -> o_ready falls after skid fills; after stall drops, consumed order is 5,6,7 with no loss; o_count=3.
- Values 8'hFE,8'hFF,8'h00,8'h01 -> o_error=0; o_sum=16'h01FE.
- Values 10,11,13,14 -> o_error=1 the cycle after 13 is consumed; o_err_value=13 and stays 13; o_count=4.
- i_clear pulsed in the same cycle as consuming value 20, then 30,31 -> 20 is not counted; o_count=2, o_sum=61, o_error=0.
- reset_n=0 with both buffer entries full -> next cycle o_count=0, o_ready=0, buffered beats never consumed.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared definitions for the handshake flipflop input stage: checker states,
// default widths and the self-backpressure LFSR constants.
package handshake_pkg;

  localparam int WIDTH_DEFAULT     = 8;
  localparam int CNT_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    CHK_SYNC = 2'd0,
    CHK_RUN  = 2'd1,
    CHK_ERR  = 2'd2
  } chk_state_e;

  // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    logic fb;
    fb = ^(state & LFSR_TAPS);
    return {state[14:0], fb};
  endfunction

endpackage

// File: rtl/handshake_skid_buffer.sv
// Two-entry (main + skid) buffer whose upstream ready is a flop, so ready
// never depends combinationally on the downstream side.
module handshake_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] main_data_r, main_data_s;
  logic             main_valid_r, main_valid_s;
  logic [WIDTH-1:0] skid_data_r, skid_data_s;
  logic             skid_valid_r, skid_valid_s;
  logic             ready_r, ready_s;
  logic             accept_s;
  logic             pop_s;

  assign accept_s = in_valid & ready_r;
  assign pop_s    = main_valid_r & out_ready;

  // Next-state of both entries; skid full implies ready_r=0, so no accept then
  always_comb begin
    main_data_s  = main_data_r;
    main_valid_s = main_valid_r;
    skid_data_s  = skid_data_r;
    skid_valid_s = skid_valid_r;
    if (pop_s && skid_valid_r) begin
      main_data_s  = skid_data_r;
      main_valid_s = 1'b1;
      skid_valid_s = 1'b0;
    end else if (accept_s) begin
      if (!main_valid_r || pop_s) begin
        main_data_s  = in_data;
        main_valid_s = 1'b1;
      end else begin
        skid_data_s  = in_data;
        skid_valid_s = 1'b1;
      end
    end else if (pop_s) begin
      main_valid_s = 1'b0;
    end else begin
      main_valid_s = main_valid_r;
    end
    ready_s = ~skid_valid_s;
  end

  // Buffer registers; ready is first raised on the edge after reset release
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      main_data_r  <= {WIDTH{1'b0}};
      main_valid_r <= 1'b0;
      skid_data_r  <= {WIDTH{1'b0}};
      skid_valid_r <= 1'b0;
      ready_r      <= 1'b0;
    end else begin
      main_data_r  <= main_data_s;
      main_valid_r <= main_valid_s;
      skid_data_r  <= skid_data_s;
      skid_valid_r <= skid_valid_s;
      ready_r      <= ready_s;
    end
  end

  assign in_ready  = ready_r;
  assign out_data  = main_data_r;
  assign out_valid = main_valid_r;

endmodule

// File: rtl/handshake_ff_input.sv
// Consumer stage: skid-buffered input, increment-by-one sequence checker and
// beat/checksum statistics. Define HANDSHAKE_FF_INPUT_STALL_EN for LFSR backpressure.
module handshake_ff_input
  import handshake_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     i_value,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_stall,
  input  logic                 i_clear,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic [CNT_WIDTH-1:0] o_sum,
  output logic                 o_error,
  output logic [WIDTH-1:0]     o_err_value
);

  localparam logic [1:0] ST_SYNC = 2'(CHK_SYNC);
  localparam logic [1:0] ST_RUN  = 2'(CHK_RUN);
  localparam logic [1:0] ST_ERR  = 2'(CHK_ERR);

  logic [WIDTH-1:0]     buf_data_s;
  logic                 buf_valid_s;
  logic                 stall_s;
  logic                 consume_s;
  logic [WIDTH-1:0]     value_inc_s;

  logic [1:0]           state_r, state_s;
  logic [WIDTH-1:0]     expected_r, expected_s;
  logic [CNT_WIDTH-1:0] count_r, count_s;
  logic [CNT_WIDTH-1:0] sum_r, sum_s;
  logic                 error_r, error_s;
  logic [WIDTH-1:0]     err_value_r, err_value_s;

  handshake_skid_buffer #(.WIDTH(WIDTH)) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_data   (i_value),
    .in_valid  (i_valid),
    .in_ready  (o_ready),
    .out_data  (buf_data_s),
    .out_valid (buf_valid_s),
    .out_ready (~stall_s)
  );

`ifdef HANDSHAKE_FF_INPUT_STALL_EN
  logic [15:0] lfsr_r;

  // Free-running self-backpressure source, about one stall cycle in four
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  assign stall_s = i_stall | (lfsr_r[1:0] == 2'b00);
`else
  assign stall_s = i_stall;
`endif

  assign consume_s   = buf_valid_s & ~stall_s;
  assign value_inc_s = buf_data_s + {{(WIDTH-1){1'b0}}, 1'b1};

  // Checker and statistics next-state; clear beats a coincident consume
  always_comb begin
    state_s     = state_r;
    expected_s  = expected_r;
    count_s     = count_r;
    sum_s       = sum_r;
    error_s     = error_r;
    err_value_s = err_value_r;
    if (i_clear) begin
      state_s     = ST_SYNC;
      expected_s  = {WIDTH{1'b0}};
      count_s     = {CNT_WIDTH{1'b0}};
      sum_s       = {CNT_WIDTH{1'b0}};
      error_s     = 1'b0;
      err_value_s = {WIDTH{1'b0}};
    end else if (consume_s) begin
      if (&count_r) begin
        count_s = count_r;
      end else begin
        count_s = count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      sum_s = sum_r + {{(CNT_WIDTH-WIDTH){1'b0}}, buf_data_s};
      case (state_r)
        ST_SYNC: begin
          expected_s = value_inc_s;
          state_s    = ST_RUN;
        end
        ST_RUN: begin
          if (buf_data_s == expected_r) begin
            expected_s = value_inc_s;
          end else begin
            error_s     = 1'b1;
            err_value_s = buf_data_s;
            state_s     = ST_ERR;
          end
        end
        ST_ERR: begin
          state_s = ST_ERR;
        end
        default: begin
          state_s = ST_SYNC;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Checker and statistics registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r     <= ST_SYNC;
      expected_r  <= {WIDTH{1'b0}};
      count_r     <= {CNT_WIDTH{1'b0}};
      sum_r       <= {CNT_WIDTH{1'b0}};
      error_r     <= 1'b0;
      err_value_r <= {WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      expected_r  <= expected_s;
      count_r     <= count_s;
      sum_r       <= sum_s;
      error_r     <= error_s;
      err_value_r <= err_value_s;
    end
  end

  assign o_count     = count_r;
  assign o_sum       = sum_r;
  assign o_error     = error_r;
  assign o_err_value = err_value_r;

endmodule

// File: tb/tb_handshake_ff_input.sv
// Self-checking bench for handshake_ff_input: vector table of sequences,
// scoreboard of accepted beats checked against checksum deltas, corner cases.
module tb_handshake_ff_input;

  logic        clock;
  logic        reset_n;
  logic [7:0]  i_value;
  logic        i_valid;
  logic        o_ready;
  logic        i_stall;
  logic        i_clear;
  logic [15:0] o_count;
  logic [15:0] o_sum;
  logic        o_error;
  logic [7:0]  o_err_value;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]  sb_q[$];
  logic [15:0] prev_count;
  logic [15:0] prev_sum;

  typedef struct packed {
    logic [31:0] vals;   // byte 0 sent first
    logic [2:0]  n;
    logic [15:0] exp_count;
    logic [15:0] exp_sum;
    logic        exp_err;
    logic [7:0]  exp_errv;
  } vec_t;

  vec_t tbl[5];

  handshake_ff_input dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_value     (i_value),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_stall     (i_stall),
    .i_clear     (i_clear),
    .o_count     (o_count),
    .o_sum       (o_sum),
    .o_error     (o_error),
    .o_err_value (o_err_value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each consumed beat must add the oldest accepted value to o_sum
  always @(negedge clock) begin
    if (reset_n === 1'b1 && o_count === prev_count + 16'd1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_beat", 32'(o_count), 32'(prev_count));
      end else begin
        check("sb_order", 32'(o_sum - prev_sum), 32'(sb_q.pop_front()));
      end
    end
    prev_count = o_count;
    prev_sum   = o_sum;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    logic ok;
    int   waits;
    i_value = v;
    i_valid = 1'b1;
    waits = 0;
    ok = 1'b0;
    while (!ok && waits < 20) begin
      ok = o_ready;
      tick();
      waits++;
    end
    if (ok) sb_q.push_back(v);
    else check("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_pulse();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  initial begin
    tbl[0] = '{vals: 32'h00030201, n: 3'd3, exp_count: 16'd3, exp_sum: 16'd6,      exp_err: 1'b0, exp_errv: 8'd0};
    tbl[1] = '{vals: 32'h0100FFFE, n: 3'd4, exp_count: 16'd4, exp_sum: 16'h01FE,   exp_err: 1'b0, exp_errv: 8'd0};
    tbl[2] = '{vals: 32'h0E0D0B0A, n: 3'd4, exp_count: 16'd4, exp_sum: 16'd48,     exp_err: 1'b1, exp_errv: 8'd13};
    tbl[3] = '{vals: 32'h0A090807, n: 3'd4, exp_count: 16'd4, exp_sum: 16'd34,     exp_err: 1'b0, exp_errv: 8'd0};
    tbl[4] = '{vals: 32'h00000505, n: 3'd2, exp_count: 16'd2, exp_sum: 16'd10,     exp_err: 1'b1, exp_errv: 8'd5};

    reset_n = 1'b0;
    i_value = 8'd0;
    i_valid = 1'b0;
    i_stall = 1'b0;
    i_clear = 1'b0;

    // Reset for three cycles, ready low throughout and one cycle after
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ready_in_reset", 32'(o_ready), 32'(0));
    end
    check("count_reset", 32'(o_count), 32'(0));
    check("sum_reset", 32'(o_sum), 32'(0));
    check("error_reset", 32'(o_error), 32'(0));
    check("errv_reset", 32'(o_err_value), 32'(0));
    reset_n = 1'b1;
    check("ready_first_cycle", 32'(o_ready), 32'(0));
    tick();
    check("ready_rises", 32'(o_ready), 32'(1));

    // Table of sequences, each from a cleared checker
    for (int k = 0; k < 5; k++) begin
      clear_pulse();
      for (int i = 0; i < int'(tbl[k].n); i++) send(tbl[k].vals[8*i +: 8]);
      idle(4);
      check($sformatf("vec%0d_count", k), 32'(o_count), 32'(tbl[k].exp_count));
      check($sformatf("vec%0d_sum", k), 32'(o_sum), 32'(tbl[k].exp_sum));
      check($sformatf("vec%0d_error", k), 32'(o_error), 32'(tbl[k].exp_err));
      check($sformatf("vec%0d_errv", k), 32'(o_err_value), 32'(tbl[k].exp_errv));
    end

    // Stall for two cycles while 5,6,7 stream: skid fills, ready drops
    clear_pulse();
    i_stall = 1'b1;
    send(8'd5);
    send(8'd6);
    check("stall_ready_low", 32'(o_ready), 32'(0));
    check("stall_no_consume", 32'(o_count), 32'(0));
    i_stall = 1'b0;
    send(8'd7);
    idle(4);
    check("stall_count", 32'(o_count), 32'(3));
    check("stall_sum", 32'(o_sum), 32'(18));
    check("stall_error", 32'(o_error), 32'(0));
    check("stall_ready_back", 32'(o_ready), 32'(1));

    // Error flag timing and stickiness of the captured value
    clear_pulse();
    send(8'd40);
    send(8'd41);
    send(8'd43);
    check("err_before_consume", 32'(o_error), 32'(0));
    i_valid = 1'b0;
    tick();
    check("err_after_consume", 32'(o_error), 32'(1));
    check("err_value_first", 32'(o_err_value), 32'(43));
    send(8'd44);
    send(8'd50);
    idle(3);
    check("err_value_sticky", 32'(o_err_value), 32'(43));
    check("err_count", 32'(o_count), 32'(5));

    // Clear coincident with consuming 20: that beat is dropped from statistics
    clear_pulse();
    send(8'd20);
    i_valid = 1'b0;
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    void'(sb_q.pop_front());
    check("clear_count_zero", 32'(o_count), 32'(0));
    send(8'd30);
    send(8'd31);
    idle(4);
    check("clear_count", 32'(o_count), 32'(2));
    check("clear_sum", 32'(o_sum), 32'(61));
    check("clear_error", 32'(o_error), 32'(0));

    // Reset with both buffer entries full discards them
    clear_pulse();
    i_stall = 1'b1;
    send(8'd60);
    send(8'd61);
    check("full_ready_low", 32'(o_ready), 32'(0));
    i_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    sb_q.delete();
    check("rst_full_count", 32'(o_count), 32'(0));
    check("rst_full_ready", 32'(o_ready), 32'(0));
    reset_n = 1'b1;
    i_stall = 1'b0;
    idle(5);
    check("rst_full_no_consume", 32'(o_count), 32'(0));
    check("rst_full_sum", 32'(o_sum), 32'(0));
    check("rst_ready_back", 32'(o_ready), 32'(1));
    check("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
